// File: rtl/div_mant_iter_pkg.sv
// Shared constants and state encoding for the iterative mantissa divider.
package div_mant_iter_pkg;

    localparam int DIV_MANT_W = 24;
    localparam int DIV_EXP_W  = 8;
    localparam int DIV_BIAS   = 127;
    localparam int EXP_MAX    = (1 << DIV_EXP_W) - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: trial subtract, emit quotient bit, shift remainder.
module div_restore_step #(
    parameter int MANT_W = 24
) (
    input  logic [MANT_W:0]   rem,
    input  logic [MANT_W-1:0] divisor,
    output logic              q_bit,
    output logic [MANT_W:0]   next_rem
);

    logic [MANT_W:0] diff;

    always_comb begin
        diff     = rem - {1'b0, divisor};
        q_bit    = (rem >= {1'b0, divisor});
        next_rem = q_bit ? {diff[MANT_W-1:0], 1'b0} : {rem[MANT_W-1:0], 1'b0};
    end

endmodule

// File: rtl/div_mant_iter.sv
// Sequential restoring mantissa divider with exponent/sign handling.
// Define DIV_RADIX4_EN to retire two quotient bits per cycle (12 iterations).
module div_mant_iter
    import div_mant_iter_pkg::*;
#(
    parameter int MANT_W = DIV_MANT_W,
    parameter int EXP_W  = DIV_EXP_W,
    parameter int BIAS   = DIV_BIAS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign_a,
    input  logic              in_sign_b,
    input  logic [EXP_W-1:0]  in_exp_a,
    input  logic [EXP_W-1:0]  in_exp_b,
    input  logic [MANT_W-1:0] in_mant_a,
    input  logic [MANT_W-1:0] in_mant_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_Exp,
    output logic [MANT_W-1:0] out_Mant,
    output logic              out_sticky,
    output logic              out_dz,
    output logic              out_ovf,
    output logic              out_unf
);

`ifdef DIV_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam int CW = $clog2(MANT_W);
    localparam int SW = EXP_W + 2;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [MANT_W:0]     rem_q, rem_d;
    logic [MANT_W-1:0]   div_q, div_d;
    logic [MANT_W-1:0]   quo_q, quo_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic                sticky_q, sticky_d;
    logic                dz_q, dz_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic                accept;
    logic [SW-1:0]       exp_sum;
    logic                sum_ovf, sum_unf;
    logic [MANT_W:0]     step_rem [STEPS+1];
    logic [STEPS-1:0]    step_q;

    // Exponent difference is carried two bits wider so the sign survives the compare.
    assign exp_sum = {2'b00, in_exp_a} - {2'b00, in_exp_b} + SW'(BIAS);
    assign sum_ovf = $signed(exp_sum) > $signed(SW'(EXP_MAX));
    assign sum_unf = $signed(exp_sum) < $signed(SW'(1));

    assign step_rem[0] = rem_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        div_restore_step #(.MANT_W(MANT_W)) u_step (
            .rem      (step_rem[g]),
            .divisor  (div_q),
            .q_bit    (step_q[STEPS-1-g]),
            .next_rem (step_rem[g+1])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        in_ready = 1'b0;

        case (state_q)
            IDLE: in_ready = 1'b1;
            ITER: begin
                rem_d = step_rem[STEPS];
                quo_d = {quo_q[MANT_W-STEPS-1:0], step_q};
                cnt_d = cnt_q - CW'(STEPS);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d  = DONE;
                    sticky_d = |step_rem[STEPS];
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        accept = in_valid && in_ready;
        if (accept) begin
            sign_d   = in_sign_a ^ in_sign_b;
            exp_d    = exp_sum[EXP_W-1:0];
            rem_d    = {1'b0, in_mant_a};
            div_d    = in_mant_b;
            quo_d    = '0;
            cnt_d    = CW'(MANT_W - 1);
            sticky_d = 1'b0;
            dz_d     = (in_mant_b == '0);
            // Zero divisor or dividend short-circuits straight to a zero quotient.
            if (in_mant_b == '0 || in_mant_a == '0) begin
                state_d = DONE;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end else begin
                state_d = ITER;
                ovf_d   = sum_ovf;
                unf_d   = sum_unf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign out_valid  = (state_q == DONE);
    assign out_sign   = sign_q;
    assign out_Exp    = exp_q;
    assign out_Mant   = quo_q;
    assign out_sticky = sticky_q;
    assign out_dz     = dz_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;

endmodule

// File: tb/tb_div_mant_iter.sv
// Self-checking bench for div_mant_iter: directed table, corner sequences, random vs. model.
module tb_div_mant_iter;

`ifdef DIV_RADIX4_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 25;
`endif

    typedef struct {
        logic        sa, sb;
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb;
        logic        e_sign;
        logic [23:0] e_mant;
        logic [7:0]  e_exp;
        logic        e_sticky, e_dz, e_ovf, e_unf;
        int          e_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic        in_sign_a, in_sign_b;
    logic [7:0]  in_exp_a, in_exp_b, out_Exp;
    logic [23:0] in_mant_a, in_mant_b, out_Mant;
    logic        out_sign, out_sticky, out_dz, out_ovf, out_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_mant_iter dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
        .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
        .in_mant_a(in_mant_a), .in_mant_b(in_mant_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_Exp(out_Exp), .out_Mant(out_Mant),
        .out_sticky(out_sticky), .out_dz(out_dz), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sa, sb, input logic [7:0] ea, eb,
                                input logic [23:0] ma, mb, input logic es,
                                input logic [23:0] em, input logic [7:0] ee,
                                input logic est, edz, eovf, eunf, input int el);
        vec_t v;
        v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb;
        v.e_sign = es; v.e_mant = em; v.e_exp = ee; v.e_sticky = est;
        v.e_dz = edz; v.e_ovf = eovf; v.e_unf = eunf; v.e_lat = el;
        return v;
    endfunction

    // Reference: exact quotient by integer division of the scaled dividend.
    function automatic vec_t model(input logic sa, sb, input logic [7:0] ea, eb,
                                   input logic [23:0] ma, mb);
        vec_t v;
        longint es;
        logic [63:0] num, q;
        v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb;
        v.e_sign = sa ^ sb;
        es = longint'({56'b0, ea}) - longint'({56'b0, eb}) + 127;
        v.e_exp = es[7:0];
        v.e_ovf = (es > 254);
        v.e_unf = (es < 1);
        v.e_dz = 1'b0; v.e_mant = '0; v.e_sticky = 1'b0; v.e_lat = LAT;
        if (mb == 0) begin
            v.e_dz = 1'b1; v.e_ovf = 1'b0; v.e_unf = 1'b0; v.e_lat = 1;
        end else if (ma == 0) begin
            v.e_ovf = 1'b0; v.e_unf = 1'b0; v.e_lat = 1;
        end else begin
            num = {40'b0, ma} << 23;
            q = num / {40'b0, mb};
            v.e_mant = q[23:0];
            v.e_sticky = (num % {40'b0, mb}) != 0;
        end
        return v;
    endfunction

    task automatic drive_op(input vec_t v);
        @(negedge clk);
        in_sign_a = v.sa; in_sign_b = v.sb;
        in_exp_a = v.ea;  in_exp_b = v.eb;
        in_mant_a = v.ma; in_mant_b = v.mb;
        in_valid = 1'b1;
        chk("in_ready_at_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input vec_t v);
        int cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc + 1), 64'(v.e_lat));
        chk("sign",   64'(out_sign),   64'(v.e_sign));
        chk("mant",   64'(out_Mant),   64'(v.e_mant));
        chk("exp",    64'(out_Exp),    64'(v.e_exp));
        chk("sticky", 64'(out_sticky), 64'(v.e_sticky));
        chk("dz",     64'(out_dz),     64'(v.e_dz));
        chk("ovf",    64'(out_ovf),    64'(v.e_ovf));
        chk("unf",    64'(out_unf),    64'(v.e_unf));
    endtask

    task automatic run(input vec_t v);
        drive_op(v);
        wait_res(v);
        @(posedge clk); #1;
        chk("drained", 64'(out_valid), 64'd0);
    endtask

    vec_t tbl[13];
    vec_t va, vb;

    initial begin
        tbl[0]  = mk(0,0,127,127,24'h800000,24'h800000, 0,24'h800000,127, 0,0,0,0, LAT);
        tbl[1]  = mk(0,0,127,127,24'h800000,24'hC00000, 0,24'h555555,127, 1,0,0,0, LAT);
        tbl[2]  = mk(1,0,127,127,24'h800000,24'h000000, 1,24'h000000,127, 0,1,0,0, 1);
        tbl[3]  = mk(0,1,127,127,24'h000000,24'h800000, 1,24'h000000,127, 0,0,0,0, 1);
        tbl[4]  = mk(0,0,254,  1,24'h800000,24'h800000, 0,24'h800000,124, 0,0,1,0, LAT);
        tbl[5]  = mk(0,0,  1,254,24'h800000,24'h800000, 0,24'h800000,130, 0,0,0,1, LAT);
        tbl[6]  = mk(1,1,128,128,24'hC00000,24'h800000, 0,24'hC00000,127, 0,0,0,0, LAT);
        tbl[7]  = mk(0,0,254,127,24'h800000,24'h800000, 0,24'h800000,254, 0,0,0,0, LAT);
        tbl[8]  = mk(0,0,  0,127,24'h800000,24'h800000, 0,24'h800000,  0, 0,0,0,1, LAT);
        tbl[9]  = mk(0,0,  1,127,24'h800000,24'h800000, 0,24'h800000,  1, 0,0,0,0, LAT);
        tbl[10] = mk(0,0,254,  1,24'h800000,24'h000000, 0,24'h000000,124, 0,1,0,0, 1);
        tbl[11] = mk(0,0,127,127,24'hFFFFFF,24'h800000, 0,24'hFFFFFF,127, 0,0,0,0, LAT);
        tbl[12] = mk(0,0,127,127,24'h800000,24'hFFFFFF, 0,24'h400000,127, 1,0,0,0, LAT);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_sign_a = 0; in_sign_b = 0; in_exp_a = 0; in_exp_b = 0;
        in_mant_a = 0; in_mant_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mant",      64'(out_Mant),  64'd0);
        chk("rst_exp",       64'(out_Exp),   64'd0);
        chk("rst_flags", 64'({out_sign, out_sticky, out_dz, out_ovf, out_unf}), 64'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 13; i++) run(tbl[i]);

        // Backpressure: result must hold while out_ready is low, then chain a new op.
        va = tbl[1];
        vb = tbl[6];
        out_ready = 1'b0;
        drive_op(va);
        wait_res(va);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid",    64'(out_valid),  64'd1);
            chk("bp_in_ready", 64'(in_ready),   64'd0);
            chk("bp_mant",     64'(out_Mant),   64'(va.e_mant));
            chk("bp_sticky",   64'(out_sticky), 64'(va.e_sticky));
        end
        out_ready = 1'b1;
        drive_op(vb);
        chk("b2b_busy", 64'(out_valid), 64'd0);
        wait_res(vb);
        @(posedge clk); #1;

        // Reset in the middle of an iteration.
        drive_op(tbl[1]);
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(in_ready),  64'd1);
        chk("midrst_mant",  64'(out_Mant),  64'd0);
        @(negedge clk) rst = 1'b0;
        run(tbl[6]);

        for (int i = 0; i < 300; i++) begin
            logic [23:0] ma, mb;
            ma = ($urandom_range(0, 15) == 0) ? 24'h0 : 24'($urandom);
            mb = ($urandom_range(0, 15) == 0) ? 24'h0 : {1'b1, 23'($urandom)};
            run(model(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), ma, mb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_mant_iter.md
Name: div_mant_iter

Overview:
- Sequential single-precision divider core. Takes unpacked sign, biased exponents and 24-bit mantissas (hidden bit included) and produces a raw quotient mantissa, biased exponent, sign and sticky bit.
- Sits directly upstream of the division normaliser. Its quotient always has its leading one at bit 23 or bit 22, so the normaliser needs at most one left shift and one exponent decrement.
- Upstream unpack logic handles NaN, Inf and denormals.

Parameters:
- MANT_W, 24, mantissa width including hidden bit.
- EXP_W, 8, biased exponent width.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in_sign_a, in_sign_b  in  1 each  operand signs.
- in_exp_a, in_exp_b  in  EXP_W each  biased exponents.
- in_mant_a, in_mant_b  in  MANT_W each  dividend and divisor mantissas.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sign  out  1  sign_a XOR sign_b.
- out_Exp  out  EXP_W  biased exponent, low bits of the internal sum.
- out_Mant  out  MANT_W  raw quotient, not normalised.
- out_sticky  out  1  final remainder is non-zero.
- out_dz  out  1  divide by zero (mant_b == 0).
- out_ovf  out  1  exponent sum > 2^EXP_W - 2.
- out_unf  out  1  exponent sum < 1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state IDLE; in_ready = 1; out_valid = 0.
  - All result registers 0 (out_sign, out_Exp, out_Mant, out_sticky, out_dz, out_ovf, out_unf).
  - Counter and remainder cleared.
- Reset mid-operation: abort at the next edge, return to IDLE, any pending result is lost.
- States: IDLE, ITER, DONE.
- in_ready = (state == IDLE) or (state == DONE and out_ready). in_valid while busy is ignored.
- Accept (in_valid and in_ready, cycle N):
  - Latch sign = a XOR b.
  - exp_sum = exp_a - exp_b + BIAS, computed signed at EXP_W+2 bits.
  - rem = {0, mant_a}, MANT_W+1 bits; divisor = mant_b; cnt = MANT_W-1.
- Special cases at accept:
  - mant_b == 0: go to DONE. out_dz = 1, out_Mant = 0, out_sticky = 0. out_valid is asserted at N+1.
  - mant_a == 0 (and mant_b != 0): go to DONE. out_Mant = 0, out_sticky = 0, out_dz = 0. out_valid at N+1.
- ITER (restoring, one bit per cycle), each cycle:
  - If rem >= divisor: q[cnt] = 1 and rem = (rem - divisor) << 1.
  - Else: q[cnt] = 0 and rem = rem << 1.
  - When cnt == 0: go to DONE and set out_sticky = (final remainder != 0).
- Latency: 24 ITER cycles. out_valid is first asserted at N+25.
- Quotient range: since mant_a < 2*mant_b, q lies in [2^22, 2^24).
- DONE:
  - out_valid = 1; all outputs held stable until out_ready.
  - On out_ready: return to IDLE, or load the new operation if in_valid is high in the same cycle (back-to-back, no bubble).
- Exponent flags, computed from the signed exp_sum:
  - out_ovf = 1 if exp_sum > 254.
  - out_unf = 1 if exp_sum < 1.
  - out_Exp = exp_sum[EXP_W-1:0] regardless of flags.
  - Both flags are forced to 0 when out_dz or the zero-dividend case is taken.

Optional Feature:
- Macro: DIV_RADIX4_EN.
- Defined: two quotient bits per cycle, using two cascaded restoring steps. 12 ITER cycles; out_valid at N+13. Results are bit-identical to the radix-2 path.
- Undefined: radix-2 as above, 24 cycles.
- Handshake and special-case latency are unchanged in both builds.

Decomposition:
- Shared FP package holds:
  - MANT_W, EXP_W, BIAS constants.
  - State enum {IDLE, ITER, DONE}.
  - The EXP_MAX = 254 constant.
- One sub-module: div_restore_step. Combinational, inputs (rem, divisor), outputs (q_bit, next_rem). Instantiated once in the radix-2 build and twice in the DIV_RADIX4_EN build.

Test Plan:
- 1.0/1.0: mant 0x800000 / 0x800000, exp 127 / 127 -> out_Mant 0x800000, out_Exp 127, out_sticky 0, out_valid at N+25 (N+13 with DIV_RADIX4_EN).
- 1.0/1.5: 0x800000 / 0xC00000, exp 127 / 127 -> out_Mant 0x555555, out_sticky 1, out_Exp 127. Leading one at bit 22.
- Divide by zero: mant_b 0 -> out_dz 1, out_Mant 0, out_valid at N+1. Zero dividend (mant_a 0) -> out_Mant 0, out_dz 0, out_valid at N+1.
- Exponent overflow: exp_a 254, exp_b 1 -> out_ovf 1. Exponent underflow: exp_a 1, exp_b 254 -> out_unf 1.
- Backpressure: hold out_ready low for 5 cycles -> outputs stable and in_ready 0. Then assert out_ready with in_valid high -> new operation accepted the same cycle and second result correct.
- Reset mid-operation: assert rst at cycle N+10 -> next cycle state IDLE, out_valid 0, in_ready 1. A subsequent 3.0/2.0 (0xC00000 / 0x800000, exp 128 / 128) -> out_Mant 0xC00000, out_Exp 127.
